// File: rtl/pipe_pkg.sv
// Shared constants for elastic pipeline stage registers.
// State encodings are {skid_valid, out_valid}.
package pipe_pkg;

    localparam int XLEN      = 32;
    localparam int REGADDR_W = 5;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL1 = 2'b01;
    localparam logic [1:0] ST_FULL2 = 2'b11;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with increment enable.
// Clears only on the asynchronous active-low reset.
module pipe_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // count up on inc, stick at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register with one-entry skid buffer.
// Optional stall/bubble counters: define PIPE_PERF_CNT_EN.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic [1:0]       state;
    logic             in_fire;
    logic             out_fire;

    // in_ready only depends on flops and reset, never on out_ready/stall
    assign in_ready = rst & ~skid_valid;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready & ~stall;
    assign state    = {skid_valid, out_valid};

    // output register plus skid entry; flush beats any fire
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= RESET_VAL;
            skid_data  <= RESET_VAL;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= RESET_VAL;
            skid_data  <= RESET_VAL;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                    end
                end
                ST_FULL1: begin
                    if (in_fire && out_fire) begin
                        out_data <= in_data;
                    end else if (in_fire) begin
                        skid_valid <= 1'b1;
                        skid_data  <= in_data;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                    end
                end
                ST_FULL2: begin
                    if (out_fire) begin
                        out_data   <= skid_data;
                        skid_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid  <= 1'b0;
                    skid_valid <= 1'b0;
                end
            endcase
        end
    end

    // a skid entry without an output entry cannot occur
    a_no_orphan_skid: assert property (
        @(posedge clk) disable iff (!rst) state != 2'b10
    );

`ifdef PIPE_PERF_CNT_EN
    logic stall_inc;
    logic bubble_inc;

    assign stall_inc  = out_valid & ~out_fire & ~flush;
    assign bubble_inc = ~out_valid;

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
